// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Optional stall/bubble performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
    parameter int unsigned DATA_W         = 152,
    parameter bit          CLEAR_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Next-state and datapath load selects; flush squashes everything.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d        = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // State and registered handshake/occupancy outputs, all derived from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d != FULL);
            out_valid <= (state_d != EMPTY);
            occupancy <= 2'(state_d);
        end
    end

    // Main and skid payload registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            if (CLEAR_ON_FLUSH) begin
                out_data <= '0;
                skid_q   <= '0;
            end
        end else begin
            if (load_main_in) begin
                out_data <= in_data;
            end else if (load_main_skid) begin
                out_data <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Saturating counters; only reset clears them, flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (!out_valid && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
